instr_encoder: RTL and testbench

Inverse of the main control decoder: accepts a 9-bit control bundle plus register/immediate fields over a valid/ready stream, recovers the opcode from the control bundle, assembles the 32-bit MIPS instruction word and emits it with a sequential instruction-memory write address. It sits in the program-load path ahead of instruction memory, so test programs can be written in terms of the same control vectors the decoder produces. Illegal bundles are dropped and counted.

---
 rtl/instr_encoder.sv | 104 ++++++++++
 tb/tb_instr_encoder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Program-load encoder: turns a main-decoder control bundle plus register and
// immediate fields back into a MIPS instruction word with a sequential address.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [8:0]        ctrl,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_instr,
  output logic              err,
  output logic [7:0]        err_count,
  output logic              wrap
);

  localparam logic [8:0] CTRL_RTYPE = 9'h122;
  localparam logic [8:0] CTRL_LW    = 9'h0F0;
  localparam logic [8:0] CTRL_SW    = 9'h088;
  localparam logic [8:0] CTRL_BEQ   = 9'h005;

  logic [ADDR_W-1:0] wr_ptr;
  logic              legal;
  logic [31:0]       word;
  logic              accept;

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready depends only on the output register and out_ready, never on
  // in_valid, so the one-entry stage can refill in the cycle it drains.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    legal = 1'b0;
    word  = '0;
    case (ctrl)
      CTRL_RTYPE: begin
        legal = 1'b1;
        word  = {6'b000000, rs, rt, rd, 5'b00000, funct};
      end
      CTRL_LW: begin
        legal = 1'b1;
        word  = {6'b100011, rs, rt, imm};
      end
      CTRL_SW: begin
        legal = 1'b1;
        word  = {6'b101011, rs, rt, imm};
      end
      CTRL_BEQ: begin
        legal = 1'b1;
        word  = {6'b000100, rs, rt, imm};
      end
      default: begin
        legal = 1'b0;
        word  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_instr <= '0;
      err       <= 1'b0;
      err_count <= '0;
      wrap      <= 1'b0;
    end else if (clr) begin
      // clr wins over a same-cycle accept; that bundle is simply dropped.
      wr_ptr    <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_instr <= '0;
      err       <= 1'b0;
      err_count <= '0;
      wrap      <= 1'b0;
    end else begin
      err <= accept && !legal;
      if (accept && legal) begin
        out_instr <= word;
        out_addr  <= wr_ptr;
        out_valid <= 1'b1;
        wr_ptr    <= wr_ptr + 1'b1;
        if (&wr_ptr) wrap <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && !legal && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: vector table plus hand-written sequences, with a
// reference model of the stream state and an expected-word queue.
module tb_instr_encoder;

  localparam int ADDR_W = 2;
  localparam int W      = ADDR_W + 32;

  logic              clk = 1'b0;
  logic              rst, clr, in_valid, in_ready, out_valid, out_ready;
  logic [8:0]        ctrl;
  logic [4:0]        rs, rt, rd;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic [ADDR_W-1:0] out_addr;
  logic [31:0]       out_instr;
  logic              err, wrap;
  logic [7:0]        err_count;

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .ctrl(ctrl), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_instr(out_instr),
    .err(err), .err_count(err_count), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic is_legal(input logic [8:0] c);
    return (c == 9'h122) || (c == 9'h0F0) || (c == 9'h088) || (c == 9'h005);
  endfunction

  function automatic logic [31:0] enc(input logic [8:0] c, input logic [4:0] s, t, d,
                                      input logic [5:0] f, input logic [15:0] i);
    case (c)
      9'h122:  return {6'b000000, s, t, d, 5'b00000, f};
      9'h0F0:  return {6'b100011, s, t, i};
      9'h088:  return {6'b101011, s, t, i};
      9'h005:  return {6'b000100, s, t, i};
      default: return 32'h0;
    endcase
  endfunction

  // Reference model of the stream state and the expected-word scoreboard.
  logic [W-1:0]      exp_q[$];
  logic [31:0]       cur_exp;
  logic              m_valid, m_err, m_wrap;
  logic [ADDR_W-1:0] m_ptr;
  logic [7:0]        m_cnt;
  logic              m_acc;

  always @(posedge clk or posedge rst) begin
    if (rst || clr) begin
      m_valid <= 1'b0; m_err <= 1'b0; m_wrap <= 1'b0; m_ptr <= '0; m_cnt <= '0;
      exp_q.delete();
    end else begin
      m_acc = in_valid && (!m_valid || out_ready);
      m_err <= m_acc && !is_legal(ctrl);
      if (m_acc && is_legal(ctrl)) begin
        exp_q.push_back({m_ptr, cur_exp});
        m_valid <= 1'b1;
        m_ptr   <= m_ptr + 1'b1;
        if (m_ptr == {ADDR_W{1'b1}}) m_wrap <= 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid <= 1'b0;
      end
      if (m_acc && !is_legal(ctrl) && m_cnt != 8'hFF) m_cnt <= m_cnt + 8'd1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", in_ready, !m_valid || out_ready);
      check("out_valid", out_valid, m_valid);
      check("err", err, m_err);
      check("err_count", err_count, m_cnt);
      check("wrap", wrap, m_wrap);
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL word: got %0h/%0h, expected nothing pending", out_addr, out_instr);
        end else begin
          check("word", {out_addr, out_instr}, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Driver: holds the bundle until the model says it is accepted.
  task automatic send(input logic [8:0] c, input logic [4:0] s, t, d,
                      input logic [5:0] f, input logic [15:0] i, input logic [31:0] e);
    logic done;
    done = 1'b0;
    in_valid = 1'b1; ctrl = c; rs = s; rt = t; rd = d; funct = f; imm = i; cur_exp = e;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (!m_valid || out_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: got no accept, expected accept of ctrl %0h", c);
    end
  endtask

  task automatic send_enc(input logic [8:0] c, input logic [4:0] s, t, d,
                          input logic [5:0] f, input logic [15:0] i);
    send(c, s, t, d, f, i, enc(c, s, t, d, f, i));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [8:0]  c;
    logic [4:0]  s, t, d;
    logic [5:0]  f;
    logic [15:0] i;
    logic        legal;
    logic [31:0] e;
  } vec_t;

  vec_t vec[9];
  logic [8:0] lg[4];
  logic [8:0] rc;
  logic [7:0] base_cnt;
  logic       rnd_done;

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ctrl = '0; rs = '0; rt = '0; rd = '0; funct = '0; imm = '0; cur_exp = '0;
    lg[0] = 9'h122; lg[1] = 9'h0F0; lg[2] = 9'h088; lg[3] = 9'h005;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_err", err, 0);
    check("rst_err_count", err_count, 0);
    check("rst_wrap", wrap, 0);
    check("rst_in_ready", in_ready, 1);
    idle(2);
    rst = 1'b0;
    out_ready = 1'b1;

    vec[0] = '{9'h122, 5'd1,  5'd2,  5'd3,  6'h20, 16'h0000, 1'b1, 32'h00221820};
    vec[1] = '{9'h0F0, 5'd29, 5'd8,  5'd0,  6'h00, 16'h0004, 1'b1, 32'h8FA80004};
    vec[2] = '{9'h088, 5'd29, 5'd9,  5'd0,  6'h00, 16'hFFFC, 1'b1, 32'hAFA9FFFC};
    vec[3] = '{9'h005, 5'd1,  5'd2,  5'd0,  6'h00, 16'hFFFF, 1'b1, 32'h1022FFFF};
    vec[4] = '{9'h122, 5'd31, 5'd0,  5'd31, 6'h2A, 16'hBEEF, 1'b1, 32'h03E0F82A};
    vec[5] = '{9'h1FF, 5'd1,  5'd1,  5'd1,  6'h01, 16'h1111, 1'b0, 32'h0};
    vec[6] = '{9'h000, 5'd2,  5'd2,  5'd2,  6'h02, 16'h2222, 1'b0, 32'h0};
    vec[7] = '{9'h123, 5'd3,  5'd3,  5'd3,  6'h03, 16'h3333, 1'b0, 32'h0};
    vec[8] = '{9'h0F0, 5'd0,  5'd31, 5'd5,  6'h3F, 16'h8000, 1'b1, 32'h8C1F8000};
    for (int v = 0; v < 9; v++) begin
      send(vec[v].c, vec[v].s, vec[v].t, vec[v].d, vec[v].f, vec[v].i, vec[v].e);
      check("vec_err", err, !vec[v].legal);
    end
    idle(2);

    // Backpressure: one word pending, second bundle must wait without loss.
    out_ready = 1'b0;
    send_enc(9'h122, 5'd4, 5'd5, 5'd6, 6'h22, 16'h0);
    fork
      send_enc(9'h088, 5'd7, 5'd8, 5'd0, 6'h0, 16'h1234);
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(2);

    // Back-to-back illegal bundles, then a legal word at the unchanged address.
    base_cnt = m_cnt;
    send_enc(9'h1FF, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0);
    check("ill1_err", err, 1);
    send_enc(9'h000, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0);
    check("ill2_err", err, 1);
    check("ill2_count", err_count, base_cnt + 8'd2);
    send_enc(9'h005, 5'd9, 5'd10, 5'd0, 6'h0, 16'h00FF);
    check("ill_after_err", err, 0);
    idle(2);

    for (int n = 0; n < 300; n++) begin
      rc = 9'($urandom_range(0, 511));
      if (is_legal(rc)) rc = 9'h1FF;
      send_enc(rc, 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom), 16'($urandom));
    end
    idle(1);
    check("sat_count", err_count, 8'hFF);

    // Pointer rollover with a 2-bit address.
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    check("clr_wrap", wrap, 0);
    for (int n = 0; n < 5; n++) send_enc(9'h0F0, 5'(n), 5'(n + 1), 5'd0, 6'h0, 16'(n * 4));
    idle(1);
    check("wrap_set", wrap, 1);
    check("wrap_addr", out_addr, 0);
    idle(3);
    check("wrap_sticky", wrap, 1);

    // clr together with a legal bundle: bundle dropped, outputs zeroed.
    out_ready = 1'b0;
    send_enc(9'h122, 5'd1, 5'd1, 5'd1, 6'h1, 16'h0);
    out_ready = 1'b1;
    in_valid = 1'b1; ctrl = 9'h088; rs = 5'd3; rt = 5'd4; imm = 16'h5555;
    cur_exp = enc(9'h088, 5'd3, 5'd4, 5'd0, 6'h0, 16'h5555);
    clr = 1'b1;
    idle(1);
    clr = 1'b0; in_valid = 1'b0;
    check("clr_out_valid", out_valid, 0);
    check("clr_out_instr", out_instr, 0);
    check("clr_out_addr", out_addr, 0);
    check("clr_err_count", err_count, 0);
    check("clr_wrap2", wrap, 0);
    idle(2);

    // Async reset while a word is pending.
    out_ready = 1'b0;
    send_enc(9'h0F0, 5'd12, 5'd13, 5'd0, 6'h0, 16'hABCD);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_instr", out_instr, 0);
    check("arst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    send_enc(9'h122, 5'd2, 5'd3, 5'd4, 6'h25, 16'h0);
    check("arst_next_addr", out_addr, 0);
    check("arst_next_instr", out_instr, enc(9'h122, 5'd2, 5'd3, 5'd4, 6'h25, 16'h0));
    idle(2);

    // Random mix with a toggling consumer.
    rnd_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 60; n++) begin
          rc = ($urandom_range(0, 4) == 0) ? 9'($urandom_range(0, 511)) : lg[$urandom_range(0, 3)];
          send_enc(rc, 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom), 16'($urandom));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    idle(4);
    check("drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
